// File: rtl/ant_nav_fsm.sv
// Wall-following navigation controller for the robot ant: synchronised and
// debounced antennas, selectable follow side, lost-wall timeout and stuck back-up.
module ant_nav_fsm #(
  parameter int DEB_CYCLES    = 4,
  parameter int LOST_TIMEOUT  = 64,
  parameter int STUCK_LIMIT   = 32,
  parameter int BACKUP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       L,
  input  logic       R,
  output logic       TL,
  output logic       TR,
  output logic       F,
  output logic       B,
  output logic [2:0] state,
  output logic       lost_evt
);

  localparam int TMAX_A = (LOST_TIMEOUT > STUCK_LIMIT) ? LOST_TIMEOUT : STUCK_LIMIT;
  localparam int TMAX   = (TMAX_A > BACKUP_CYCLES) ? TMAX_A : BACKUP_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int DW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_LOST   = 3'd0,
    S_ROT    = 3'd1,
    S_WALL1  = 3'd2,
    S_WALL2  = 3'd3,
    S_BACKUP = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg;
  logic          mode_reg;
  logic          lost_reg, lost_next;
  logic [1:0]    pin_w;
  logic [1:0]    deb_w;
  logic          dl, dr, contact, near, far;
  logic          tl0, tr0;

  assign pin_w = {L, R};

  // Bit 1 is the left antenna, bit 0 the right one.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ant
      logic          s1_reg, s2_reg, d_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          d_reg   <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg <= pin_w[gi];
          s2_reg <= s1_reg;
          if (s2_reg != d_reg) begin
            if (cnt_reg == DW'(DEB_CYCLES - 1)) begin
              d_reg   <= s2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + DW'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign deb_w[gi] = d_reg;
    end
  endgenerate

  assign dl      = deb_w[1];
  assign dr      = deb_w[0];
  assign contact = dl | dr;
  assign near    = mode_reg ? dl : dr;
  assign far     = mode_reg ? dr : dl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_LOST;
      timer_reg <= '0;
      mode_reg  <= 1'b0;
      lost_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      lost_reg  <= lost_next;
      if (state_next != state_reg) begin
        timer_reg <= '0;
      end else if (en && (timer_reg != TW'(TMAX))) begin
        timer_reg <= timer_reg + TW'(1);
      end
      if (en && (state_reg == S_LOST)) begin
        mode_reg <= mode;
      end
    end
  end

  // Illegal codes recover even while frozen so the block can never stick there.
  always_comb begin
    state_next = state_reg;
    lost_next  = 1'b0;
    case (state_reg)
      S_LOST: begin
        if (en && contact) state_next = S_ROT;
      end
      S_ROT: begin
        if (en) begin
          if (!contact)                                state_next = S_ROT == S_ROT ? S_WALL1 : S_ROT;
          else if (timer_reg == TW'(STUCK_LIMIT - 1))  state_next = S_BACKUP;
        end
      end
      S_WALL1: begin
        if (en) begin
          if (near) begin
            state_next = S_WALL2;
          end else if (timer_reg == TW'(LOST_TIMEOUT - 1)) begin
            state_next = S_LOST;
            lost_next  = 1'b1;
          end
        end
      end
      S_WALL2: begin
        if (en) begin
          if (far)       state_next = S_ROT;
          else if (!near) state_next = S_WALL1;
        end
      end
      S_BACKUP: begin
        if (en && (timer_reg == TW'(BACKUP_CYCLES - 1))) state_next = S_ROT;
      end
      default: state_next = S_LOST;
    endcase
  end

  // Turn commands are decoded for right-wall following, then mirrored for left.
  always_comb begin
    tl0 = 1'b0;
    tr0 = 1'b0;
    F   = 1'b0;
    B   = 1'b0;
    if (en) begin
      case (state_reg)
        S_LOST:   F = 1'b1;
        S_ROT:    tl0 = 1'b1;
        S_WALL1:  begin F = 1'b1; tr0 = 1'b1; end
        S_WALL2:  begin F = 1'b1; tl0 = 1'b1; end
        S_BACKUP: B = 1'b1;
        default:  F = 1'b0;
      endcase
    end
  end

  assign TL       = mode_reg ? tr0 : tl0;
  assign TR       = mode_reg ? tl0 : tr0;
  assign state    = state_reg;
  assign lost_evt = lost_reg & en;

endmodule

// File: tb/tb_ant_nav_fsm.sv
// Randomised bench for ant_nav_fsm, checked every cycle against a behavioural model.
module tb_ant_nav_fsm;

  localparam int DEB  = 2;
  localparam int LT   = 8;
  localparam int SL   = 6;
  localparam int BC   = 3;
  localparam int TMAX = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       L = 1'b0;
  logic       R = 1'b0;
  logic       TL, TR, F, B, lost_evt;
  logic [2:0] state;

  always #5 clk = ~clk;

  ant_nav_fsm #(
    .DEB_CYCLES(DEB), .LOST_TIMEOUT(LT), .STUCK_LIMIT(SL), .BACKUP_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .L(L), .R(R),
    .TL(TL), .TR(TR), .F(F), .B(B), .state(state), .lost_evt(lost_evt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  // Model: 0 LOST, 1 ROT, 2 WALL1, 3 WALL2, 4 BACKUP
  int m_state, m_timer;
  bit m_mode, m_dl, m_dr, m_lost;
  bit pl[2], pr[2];
  bit hl[$], hr[$];

  function automatic bit all_differ(input bit q[$], input bit d);
    foreach (q[i]) if (q[i] == d) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int nxt;
    bit nr, fr, evt, sl_v, sr_v;
    if (rst) begin
      m_state = 0; m_timer = 0; m_mode = 0; m_dl = 0; m_dr = 0; m_lost = 0;
      pl[0] = 0; pl[1] = 0; pr[0] = 0; pr[1] = 0;
      hl.delete(); hr.delete();
      return;
    end
    nxt = m_state;
    nr  = m_mode ? m_dl : m_dr;
    fr  = m_mode ? m_dr : m_dl;
    evt = 0;
    if (en) begin
      if (m_state == 0) begin
        if (m_dl || m_dr) nxt = 1;
      end else if (m_state == 1) begin
        if (!(m_dl || m_dr)) nxt = 2;
        else if (m_timer == SL - 1) nxt = 4;
      end else if (m_state == 2) begin
        if (nr) nxt = 3;
        else if (m_timer == LT - 1) begin nxt = 0; evt = 1; end
      end else if (m_state == 3) begin
        if (fr) nxt = 1;
        else if (!nr) nxt = 2;
      end else begin
        if (m_timer == BC - 1) nxt = 1;
      end
      if (m_state == 0) m_mode = mode;
      m_timer = (nxt != m_state) ? 0 : ((m_timer < TMAX) ? m_timer + 1 : TMAX);
    end
    m_state = nxt;
    m_lost  = evt;
    // Pins reach the debouncer two edges later; it flips after DEB consecutive disagreeing samples.
    sl_v = pl[1]; pl[1] = pl[0]; pl[0] = L;
    sr_v = pr[1]; pr[1] = pr[0]; pr[0] = R;
    hl.push_back(sl_v); if (hl.size() > DEB) void'(hl.pop_front());
    hr.push_back(sr_v); if (hr.size() > DEB) void'(hr.pop_front());
    if (hl.size() == DEB && all_differ(hl, m_dl)) m_dl = ~m_dl;
    if (hr.size() == DEB && all_differ(hr, m_dr)) m_dr = ~m_dr;
  endtask

  function automatic logic [4:0] exp_out();
    bit a, b, f, bk;
    a = 0; b = 0; f = 0; bk = 0;
    case (m_state)
      0: f = 1;
      1: a = 1;
      2: begin f = 1; b = 1; end
      3: begin f = 1; a = 1; end
      default: bk = 1;
    endcase
    if (!en) return 5'b0;
    return {(m_mode ? b : a), (m_mode ? a : b), f, bk, m_lost};
  endfunction

  task automatic cyc(input bit r_v, input bit e_v, input bit m_v, input bit l_v, input bit rr_v);
    @(negedge clk);
    rst = r_v; en = e_v; mode = m_v; L = l_v; R = rr_v;
    @(posedge clk);
    model_step();
    #1;
    n_cyc++;
    $display("cyc %0d rst=%0b en=%0b mode=%0b L=%0b R=%0b state=%0d TL=%0b TR=%0b F=%0b B=%0b evt=%0b",
             n_cyc, rst, en, mode, L, R, state, TL, TR, F, B, lost_evt);
    check("state", 8'(state), 8'(m_state));
    check("outputs", 8'({TL, TR, F, B, lost_evt}), 8'(exp_out()));
    check("inv_turn", 8'(TL & TR), 8'd0);
    check("inv_back", 8'(B & F), 8'd0);
  endtask

  initial begin
    int lat;
    bit lv, rv, mv, ev, rs;
    int len;

    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("reset_state", 8'(state), 8'd0);
    check("reset_out", 8'({TL, TR, F, B, lost_evt}), 8'b00100);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);
    check("idle_state", 8'(state), 8'd0);

    // Single-cycle glitch must be filtered, then a held contact lands on edge 5.
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    check("glitch_state", 8'(state), 8'd0);
    lat = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, 0, 0, 1);
      if (state == 3'd1 && lat == 0) lat = i;
    end
    check("deb_latency", 8'(lat), 8'd5);

    // Right-wall walk: release, R again, L, release; then lost timeout.
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 1);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);
    // Stuck: continuous contact cycles ROT/BACKUP.
    for (int i = 0; i < 40; i++) cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0);
    // Left-wall mode, mode toggling in WALL1, and an enable pause.
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0);

    for (int blk = 0; blk < 160; blk++) begin
      len = $urandom_range(1, 14);
      lv  = 1'($urandom_range(0, 1));
      rv  = 1'($urandom_range(0, 1));
      mv  = 1'($urandom_range(0, 1));
      ev  = ($urandom_range(0, 9) != 0);
      rs  = ($urandom_range(0, 59) == 0);
      for (int j = 0; j < len; j++) cyc(rs && (j == 0), ev, mv, lv, rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ant_nav_fsm.md
Name: ant_nav_fsm

Overview:
- Parametrised wall-following navigation controller for the robot ant; next generation of the 4-state LOST/rotate/wall controller.
- Adds antenna debounce, a selectable follow side (right-hand or left-hand wall), a lost-wall timeout and stuck detection with a timed back-up manoeuvre.
- Sits between the antenna sensor pins and the motor driver; drives turn, forward and backward commands.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles needed before a synchronised antenna change is accepted. Legal range is 1 or more.
- LOST_TIMEOUT, 64: cycles spent in WALL1 without near-side contact before the block declares LOST. Legal range is 2 or more.
- STUCK_LIMIT, 32: cycles of continuous contact in ROT before entering BACKUP. Legal range is 2 or more.
- BACKUP_CYCLES, 8: number of cycles BACKUP is held. Legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  1 = navigate; 0 = freeze FSM and timer, motors off
- mode  in  1  0 = follow right wall (near = R); 1 = follow left wall (near = L)
- L  in  1  left antenna, asynchronous
- R  in  1  right antenna, asynchronous
- TL  out  1  turn left
- TR  out  1  turn right
- F  out  1  forward
- B  out  1  backward
- state  out  3  current state: LOST=0, ROT=1, WALL1=2, WALL2=3, BACKUP=4
- lost_evt  out  1  one-cycle pulse when WALL1 times out to LOST

Behaviour:
- Reset (rst=1 at an edge):
  - state=LOST, timer=0, mode register=0.
  - Sync flops, debounced L/R and debounce counters all cleared to 0.
  - Outputs after reset: F=1, TL=TR=B=0, lost_evt=0, state=0.
  - Reset mid-manoeuvre (including BACKUP) aborts immediately.
- Input sync: L and R each pass through a 2-flop synchroniser.
- Debounce, per antenna:
  - The counter increments while the synchronised value differs from the debounced value.
  - The counter clears to 0 on any match.
  - On a mismatch with counter == DEB_CYCLES-1, the debounced value takes the new value and the counter clears.
  - A single-cycle glitch never reaches the FSM when DEB_CYCLES is 2 or more.
  - Latency from a pin change to a state change is DEB_CYCLES+3 rising edges.
- Mode latch:
  - mode is captured into the mode register only on cycles where state==LOST and en=1.
  - Changes to mode in any other state are ignored until the block returns to LOST.
- Side mapping:
  - Mode register 0: near=dR, far=dL.
  - Mode register 1: near=dL, far=dR.
  - Here dL and dR are the debounced antennas.
- Timer:
  - A single timer, saturating at max(LOST_TIMEOUT, STUCK_LIMIT, BACKUP_CYCLES).
  - Cleared on every state change; increments every en=1 cycle otherwise.
- FSM transitions (next state registered; evaluated only when en=1):
  - LOST: any contact (dL or dR) -> ROT; otherwise stay.
  - ROT, no contact -> WALL1.
  - ROT, contact with timer == STUCK_LIMIT-1 -> BACKUP.
  - ROT, otherwise stay.
  - WALL1, near -> WALL2.
  - WALL1, no near with timer == LOST_TIMEOUT-1 -> LOST, and lost_evt=1 on that edge.
  - WALL1, otherwise stay.
  - WALL2, far -> ROT (far has priority).
  - WALL2, near and no far -> stay.
  - WALL2, neither -> WALL1.
  - BACKUP, timer == BACKUP_CYCLES-1 -> ROT, regardless of antennas.
  - BACKUP, otherwise stay.
  - Illegal state codes 5-7 -> LOST on the next edge.
- Outputs are Moore, decoded from the state register and the mode register. Listed for mode register 0; for mode register 1 TL and TR are swapped.
  - LOST: F=1.
  - ROT: TL=1.
  - WALL1: F=1, TR=1.
  - WALL2: F=1, TL=1.
  - BACKUP: B=1.
  - Outputs not listed for a state are 0.
- Output invariants:
  - TL and TR are never both 1.
  - B=1 implies F=0.
- en=0:
  - State and timer hold; lost_evt=0.
  - TL=TR=F=B=0.
  - Synchronisers and debouncers keep running.
  - On en returning to 1, the FSM resumes from the held state and timer.
- Simultaneous events:
  - In WALL2, when far and near are both asserted, the far rule wins (-> ROT).
  - rst overrides en.

Test Plan (DEB_CYCLES=2, LOST_TIMEOUT=8, STUCK_LIMIT=6, BACKUP_CYCLES=3 unless stated):
1. Reset then idle: rst=1 for 2 cycles, L=R=0 -> state=0, F=1, TL=TR=B=0, and state stays 0 for 20 cycles.
2. Debounce: R high for 1 cycle -> state stays 0. R held high -> state=1 with TL=1 on exactly the 5th rising edge after R rises.
3. Right-wall follow, mode=0:
   - Contact, then release -> WALL1 (F=1, TR=1).
   - R again -> WALL2 (F=1, TL=1).
   - L during WALL2 -> ROT.
   - L=R=0 from WALL2 -> WALL1.
4. Lost timeout: enter WALL1, keep R=0 -> state returns to 0 after 8 cycles in WALL1, with lost_evt high for exactly 1 cycle.
5. Stuck/backup: hold L=1 continuously -> ROT for 6 cycles, then BACKUP (B=1, F=0) for 3 cycles, then ROT, and the cycle repeats.
6. Mode and enable:
   - With mode=1: contact then release -> WALL1 shows TL=1 (mirrored); near is now L.
   - Toggling mode in WALL1 has no effect.
   - en=0 in WALL1 for 10 cycles -> all motor outputs 0 and no timeout; on re-enable the remaining timeout is unchanged.
